vga_timing_gen: RTL

Parametrised VGA timing and pixel-output engine, successor to the fixed 640x480 generator.
- Generates hsync/vsync, data-enable and active-area pixel coordinates from a programmable timing set.
- Issues a one-cycle-ahead fetch request so a frame buffer or scope renderer can return a colour index in time.
- Converts that index to RGB565 through a palette ROM or a direct RGB332 expansion, with all outputs registered and mutually aligned.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_color_map.sv | 27 ++
 rtl/vga_timing_gen.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared constants for the VGA timing engine: 640x480@60 timing
//           defaults, the 32-entry RGB565 palette and RGB332 expansion.
// Revision: 1.0  initial release
// ============================================================================
package vga_pkg;

    // 640x480@60 timing set (800 x 521 total)
    localparam int c_def_h_sync   = 96;
    localparam int c_def_h_bp     = 48;
    localparam int c_def_h_active = 640;
    localparam int c_def_h_fp     = 16;
    localparam int c_def_v_sync   = 2;
    localparam int c_def_v_bp     = 29;
    localparam int c_def_v_active = 480;
    localparam int c_def_v_fp     = 10;

    // Palette shared by every renderer in MODE 0 (RGB565)
    localparam logic [15:0] c_palette [32] = '{
        16'h0000, 16'h001F, 16'h07E0, 16'h07FF, 16'hF800, 16'hF81F, 16'hFFE0, 16'hFFFF,
        16'hF800, 16'hFBE0, 16'hFFE0, 16'hAFE5, 16'h07E0, 16'h07EF, 16'h041F, 16'h801F,
        16'h8410, 16'hC618, 16'h4208, 16'h2104, 16'h07FF, 16'h0410, 16'h8000, 16'h0010,
        16'h8010, 16'h8400, 16'h0400, 16'hFD20, 16'hFEA0, 16'hA145, 16'hFC18, 16'hB71C
    };

    // Expand RGB332 to RGB565 by replicating the high bits into the low bits
    function automatic logic [15:0] rgb332_to_565(input logic [7:0] c);
        return {c[7:5], c[7:6], c[4:2], c[4:2], c[1:0], c[1:0], c[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen_if
// Purpose : Fetch handshake and video output bundle of the VGA timing engine.
//           master = timing engine, slave = frame buffer / display side.
// Revision: 1.0  initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             fetch_valid;
    logic [CNT_W-1:0] fetch_x;
    logic [CNT_W-1:0] fetch_y;
    logic [7:0]       color;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [4:0]       red;
    logic [5:0]       green;
    logic [4:0]       blue;
    logic             line_start;
    logic             frame_start;

    modport master (
        output fetch_valid, fetch_x, fetch_y,
        input  color,
        output hsync, vsync, de, red, green, blue, line_start, frame_start
    );

    modport slave (
        input  fetch_valid, fetch_x, fetch_y,
        output color,
        input  hsync, vsync, de, red, green, blue, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_color_map.sv
`default_nettype none
// ============================================================================
// Module  : vga_color_map
// Purpose : Combinational colour index to RGB565 converter.
//           MODE 0: 32-entry palette, indices >= 32 are black.
//           MODE 1: direct RGB332 expansion.
// Revision: 1.0  initial release
// ============================================================================
module vga_color_map
    import vga_pkg::*;
#(
    parameter int MODE = 0
) (
    input  wire  [7:0]  i_index,
    output logic [15:0] o_rgb
);

    generate
        if (MODE == 1) begin : g_rgb332
            assign o_rgb = rgb332_to_565(i_index);
        end else begin : g_palette
            assign o_rgb = (i_index[7:5] == 3'b000) ? c_palette[i_index[4:0]] : 16'h0000;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Purpose : Programmable VGA timing generator with one-cycle-ahead pixel
//           fetch and registered, mutually aligned sync/de/RGB outputs.
//           Counter position -> outputs is exactly two ce cycles.
// Revision: 1.0  initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC    = c_def_h_sync,
    parameter int H_BP      = c_def_h_bp,
    parameter int H_ACTIVE  = c_def_h_active,
    parameter int H_FP      = c_def_h_fp,
    parameter int V_SYNC    = c_def_v_sync,
    parameter int V_BP      = c_def_v_bp,
    parameter int V_ACTIVE  = c_def_v_active,
    parameter int V_FP      = c_def_v_fp,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int MODE      = 0,
    parameter int CNT_W     = 10
) (
    input wire               dclk,
    input wire               clr_n,
    input wire               ce,
    vga_timing_gen_if.master bus
);

    localparam int c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] c_h_last  = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_h_start = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] c_h_end   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] c_h_sync  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] c_v_last  = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_v_start = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] c_v_end   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_sync  = CNT_W'(V_SYNC);
    localparam logic             c_hs_on   = (HSYNC_POL != 0);
    localparam logic             c_vs_on   = (VSYNC_POL != 0);

    // Reject timing sets that overflow the counters or have empty porches/syncs
    generate
        if (c_h_total >= (1 << CNT_W) || c_v_total >= (1 << CNT_W) ||
            H_SYNC == 0 || H_BP == 0 || H_FP == 0 ||
            V_SYNC == 0 || V_BP == 0 || V_FP == 0) begin : g_param_check
            $error("vga_timing_gen: illegal timing parameters for CNT_W");
        end
    endgenerate

    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_vc;
    logic             w_fetch_valid;
    logic [CNT_W-1:0] w_fetch_x;
    logic [CNT_W-1:0] w_fetch_y;
    logic             r_s1_hs;
    logic             r_s1_vs;
    logic             r_s1_valid;
    logic             r_s1_first_x;
    logic             r_s1_first_xy;
    logic [15:0]      w_rgb;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [15:0]      r_rgb;
    logic             r_line_start;
    logic             r_frame_start;

    // Raster counters: hc wraps at line end and carries into vc
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (ce) begin
            if (r_hc == c_h_last) begin
                r_hc <= '0;
                r_vc <= (r_vc == c_v_last) ? '0 : r_vc + CNT_W'(1);
            end else begin
                r_hc <= r_hc + CNT_W'(1);
            end
        end
    end

    // Stage 0: active-area decode and fetch coordinates straight from counters
    always_comb begin
        w_fetch_valid = (r_hc >= c_h_start) && (r_hc < c_h_end) &&
                        (r_vc >= c_v_start) && (r_vc < c_v_end);
        w_fetch_x     = '0;
        w_fetch_y     = '0;
        if (w_fetch_valid) begin
            w_fetch_x = r_hc - c_h_start;
            w_fetch_y = r_vc - c_v_start;
        end
    end

    // Stage 1: raw syncs, fetch validity and first-pixel flags
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_s1_hs       <= 1'b0;
            r_s1_vs       <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_first_x  <= 1'b0;
            r_s1_first_xy <= 1'b0;
        end else if (ce) begin
            r_s1_hs       <= (r_hc < c_h_sync);
            r_s1_vs       <= (r_vc < c_v_sync);
            r_s1_valid    <= w_fetch_valid;
            r_s1_first_x  <= w_fetch_valid && (w_fetch_x == '0);
            r_s1_first_xy <= w_fetch_valid && (w_fetch_x == '0) && (w_fetch_y == '0);
        end
    end

    // The colour returned for the stage-1 fetch arrives now, so it is
    // converted combinationally and registered together with stage 2
    vga_color_map #(
        .MODE (MODE)
    ) u_color_map (
        .i_index (bus.color),
        .o_rgb   (w_rgb)
    );

    // Stage 2: polarity-corrected syncs, data enable and blanked RGB
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_hsync <= ~c_hs_on;
            r_vsync <= ~c_vs_on;
            r_de    <= 1'b0;
            r_rgb   <= 16'h0000;
        end else if (ce) begin
            r_hsync <= r_s1_hs ? c_hs_on : ~c_hs_on;
            r_vsync <= r_s1_vs ? c_vs_on : ~c_vs_on;
            r_de    <= r_s1_valid;
            r_rgb   <= r_s1_valid ? w_rgb : 16'h0000;
        end
    end

    // Start pulses last one dclk, even when ce stays low afterwards
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= ce && r_s1_first_x;
            r_frame_start <= ce && r_s1_first_xy;
        end
    end

    assign bus.fetch_valid = w_fetch_valid;
    assign bus.fetch_x     = w_fetch_x;
    assign bus.fetch_y     = w_fetch_y;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.de          = r_de;
    assign bus.red         = r_rgb[15:11];
    assign bus.green       = r_rgb[10:5];
    assign bus.blue        = r_rgb[4:0];
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire
